control_fsm: RTL

Multi-cycle control unit that fetches RV32I instructions, decodes them and drives the ALU's `ctrl`, `imm` and `imm_en` inputs. It sits upstream of the ALU and register file and is the initiator of the ALU control interface. The register file and the ALU are consumers of this block's outputs. It reads the ALU `N`/`Z` flags back to resolve conditional branches, and it owns the PC.

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/imm_gen.sv | 20 ++
 rtl/control_fsm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes,
// ALU control codes, branch funct3 codes, the FSM state type and small
// decode helpers.
package cpu_pkg;

   // Supported major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // ALU ctrl codes ({funct7, funct3}), matching the ALU's decode
   localparam logic [9:0] ALU_ADD  = 10'b0000000000;
   localparam logic [9:0] ALU_SUB  = 10'b0100000000;
   localparam logic [9:0] ALU_NONE = 10'b0000000000;

   // Branch funct3 codes handled by this unit
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   // True for the opcodes this control unit can sequence
   function automatic logic is_supported_opcode(input logic [6:0] opc);
      logic ok;
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_JAL: ok = 1'b1;
         default:                                 ok = 1'b0;
      endcase
      return ok;
   endfunction

   // True for the branch funct3 codes whose condition we can resolve from N/Z
   function automatic logic is_supported_branch(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_BEQ, F3_BNE, F3_BLT, F3_BGE: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Branch condition from the SUB result flags
   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic       n,
                                         input logic       z);
      logic t;
      case (f3)
         F3_BEQ:  t = z;
         F3_BNE:  t = ~z;
         F3_BLT:  t = n;
         F3_BGE:  t = ~n;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: produces the sign-extended I, B and J immediates
// from the instruction word. Bits [6:0] never contribute, so only
// [31:7] is taken in.
module imm_gen
   import cpu_pkg::*;
(
   input  logic [31:7] ir,
   output logic [31:0] imm_i,
   output logic [31:0] imm_b,
   output logic [31:0] imm_j
);

   // Pure bit shuffles with sign extension from ir[31]
   always_comb begin
      imm_i = {{20{ir[31]}}, ir[31:20]};
      imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> WB per instruction,
// with a HALT sink for unsupported encodings. Owns the PC and the IR and
// drives the ALU control interface. All outputs come from flops; rd_we and
// instr_req are additionally masked by rst_n so they drop in the reset cycle.
module control_fsm
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic        instr_req,
   output logic [31:0] instr_addr,
   input  logic        instr_valid,
   input  logic [31:0] instr_data,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic        wb_sel,
   output logic [9:0]  alu_ctrl,
   output logic [31:0] alu_imm,
   output logic        alu_imm_en,
   input  logic        alu_n,
   input  logic        alu_z,
   output logic [31:0] pc,
   output logic        illegal
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        taken_q, taken_d;
   logic [4:0]  rs1_q, rs1_d;
   logic [4:0]  rs2_q, rs2_d;
   logic [4:0]  rd_q, rd_d;
   logic        instr_req_q, instr_req_d;
   logic        rd_we_q, rd_we_d;
   logic        wb_sel_q, wb_sel_d;
   logic [9:0]  alu_ctrl_q, alu_ctrl_d;
   logic [31:0] alu_imm_q, alu_imm_d;
   logic        alu_imm_en_q, alu_imm_en_d;
   logic        illegal_q, illegal_d;

   logic [31:0] imm_i_s, imm_b_s, imm_j_s;
   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic        accept_s;
   logic        writes_rd_s;

   imm_gen u_imm_gen (
      .ir    (ir_q[31:7]),
      .imm_i (imm_i_s),
      .imm_b (imm_b_s),
      .imm_j (imm_j_s)
   );

   assign opcode_s    = ir_q[6:0];
   assign funct3_s    = ir_q[14:12];
   assign accept_s    = instr_req && instr_valid;
   assign writes_rd_s = (opcode_s == OPC_OP) || (opcode_s == OPC_OP_IMM) ||
                        (opcode_s == OPC_JAL);

   // Next-state and next-output logic for the instruction sequencer
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      taken_d      = taken_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      illegal_d    = illegal_q;
      instr_req_d  = 1'b0;
      rd_we_d      = 1'b0;
      wb_sel_d     = 1'b0;
      alu_ctrl_d   = ALU_NONE;
      alu_imm_d    = 32'd0;
      alu_imm_en_d = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (accept_s) begin
               ir_d    = instr_data;
               rs1_d   = instr_data[19:15];
               rs2_d   = instr_data[24:20];
               rd_d    = instr_data[11:7];
               state_d = S_DECODE;
            end else begin
               instr_req_d = 1'b1;
            end
         end
         S_DECODE: begin
            if (is_supported_opcode(opcode_s)) begin
               state_d = S_EXEC;
               case (opcode_s)
                  OPC_OP: begin
                     alu_ctrl_d = {ir_q[31:25], funct3_s};
                  end
                  OPC_OP_IMM: begin
                     alu_ctrl_d   = {ir_q[31:25], funct3_s};
                     alu_imm_d    = imm_i_s;
                     alu_imm_en_d = 1'b1;
                  end
                  OPC_BRANCH: begin
                     alu_ctrl_d = ALU_SUB;
                  end
                  default: begin
                     alu_ctrl_d = ALU_NONE;
                  end
               endcase
            end else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            // Flags are valid while EXEC drives the ALU; capture the decision now
            taken_d = (opcode_s == OPC_BRANCH) ? branch_taken(funct3_s, alu_n, alu_z) : 1'b0;
            if ((opcode_s == OPC_BRANCH) && !is_supported_branch(funct3_s)) begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end else begin
               state_d  = S_WB;
               rd_we_d  = writes_rd_s && (rd_q != 5'd0);
               wb_sel_d = (opcode_s == OPC_JAL);
            end
         end
         S_WB: begin
            if (taken_q) begin
               pc_d = pc_q + imm_b_s;
            end else if (opcode_s == OPC_JAL) begin
               pc_d = pc_q + imm_j_s;
            end else begin
               pc_d = pc_q + 32'd4;
            end
            taken_d     = 1'b0;
            instr_req_d = 1'b1;
            state_d     = S_FETCH;
         end
         S_HALT: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
         end
         default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
         end
      endcase
   end

   // State, PC, IR and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= 32'd0;
         taken_q      <= 1'b0;
         rs1_q        <= 5'd0;
         rs2_q        <= 5'd0;
         rd_q         <= 5'd0;
         instr_req_q  <= 1'b0;
         rd_we_q      <= 1'b0;
         wb_sel_q     <= 1'b0;
         alu_ctrl_q   <= 10'd0;
         alu_imm_q    <= 32'd0;
         alu_imm_en_q <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         taken_q      <= taken_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         instr_req_q  <= instr_req_d;
         rd_we_q      <= rd_we_d;
         wb_sel_q     <= wb_sel_d;
         alu_ctrl_q   <= alu_ctrl_d;
         alu_imm_q    <= alu_imm_d;
         alu_imm_en_q <= alu_imm_en_d;
         illegal_q    <= illegal_d;
      end
   end

   assign instr_req  = instr_req_q & rst_n;
   assign instr_addr = pc_q;
   assign rs1_addr   = rs1_q;
   assign rs2_addr   = rs2_q;
   assign rd_addr    = rd_q;
   assign rd_we      = rd_we_q & rst_n;
   assign wb_sel     = wb_sel_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign alu_imm    = alu_imm_q;
   assign alu_imm_en = alu_imm_en_q;
   assign pc         = pc_q;
   assign illegal    = illegal_q;

endmodule
